// File: rtl/clk50k_monitor.sv
// clk50k_monitor: receive side of the divided-clock path.
// Synchronizes the slow divider clock clk_in into the clk domain and emits one-cycle
// rise/fall enables. Also measures every half-period in clk cycles and tracks lock/loss
// against the expected divider ratio.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous reset, active low
//   clk_in        slow divided clock, asynchronous to clk
//   clr_lost      one-cycle clear of lost_sticky
//   rise_pulse    one-cycle pulse per rising edge of clk_in
//   fall_pulse    one-cycle pulse per falling edge of clk_in
//   half_period   last measured half-period, in clk cycles
//   period_valid  one-cycle pulse when half_period updates
//   locked        high while the monitor is locked
//   lost_sticky   set when lock is lost; held until clr_lost
//
// Build option: define CLKMON_GLITCH_FILTER_EN to add a FILT_LEN-cycle glitch filter on
// the synchronized level. This adds the FILT_LEN parameter. Without the define, the
// synchronizer output drives the edge logic directly.
module clk50k_monitor #(
  parameter int unsigned EXP_HALF = 100,
  parameter int unsigned TOL      = 2,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 400,
  parameter int unsigned CNT_W    = 16
`ifdef CLKMON_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILT_LEN = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             clr_lost,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost_sticky
);

  localparam int unsigned MEAS_W = CNT_W + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] LOCKED = 2'd1;
  localparam logic [1:0] LOST   = 2'd2;

  logic              sync0;
  logic              sync1;
  logic              prev;
  logic              lvl;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_nxt;
  logic              armed;
  logic              armed_nxt;
  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic              edge_c;
  logic              timeout_c;
  logic              in_tol_c;
  logic [MEAS_W-1:0] meas_c;
  logic [MEAS_W-1:0] diff_c;

  // Two-flop synchronizer for the asynchronous slow clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= clk_in;
      sync1 <= sync0;
    end
  end

`ifdef CLKMON_GLITCH_FILTER_EN
  localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);

  logic [FILT_W-1:0] filt_cnt;
  logic              filt_lvl;

  // The level follows sync1 only after sync1 has disagreed for FILT_LEN cycles in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (sync1 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      filt_lvl <= sync1;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync1;
`endif

  assign edge_c    = lvl ^ prev;
  assign timeout_c = !edge_c && (cnt == CNT_W'(TIMEOUT - 1));

  // Tolerance check on the candidate measurement, one bit wider so cnt+1 cannot wrap.
  always_comb begin
    meas_c = MEAS_W'(cnt) + MEAS_W'(1);
    if (meas_c >= MEAS_W'(EXP_HALF)) begin
      diff_c = meas_c - MEAS_W'(EXP_HALF);
    end else begin
      diff_c = MEAS_W'(EXP_HALF) - meas_c;
    end
    in_tol_c = (diff_c <= MEAS_W'(TOL));
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEARCH;
      good  <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
      armed <= armed_nxt;
    end
  end

  // Lock FSM next state. Any edge arms the measurement; only armed edges are measured.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    armed_nxt = armed;
    case (state)
      SEARCH: begin
        if (edge_c) begin
          armed_nxt = 1'b1;
          if (armed) begin
            if (in_tol_c) begin
              good_nxt = good + GOOD_W'(1);
              if (good == GOOD_W'(LOCK_CNT - 1)) begin
                state_nxt = LOCKED;
              end
            end else begin
              good_nxt = '0;
            end
          end
        end else if (timeout_c) begin
          good_nxt  = '0;
          armed_nxt = 1'b0;
        end
      end
      LOCKED: begin
        if ((edge_c && armed && !in_tol_c) || timeout_c) begin
          state_nxt = LOST;
        end
      end
      LOST: begin
        // An edge here is still measured; the next edge after this cycle only re-arms.
        state_nxt = SEARCH;
        good_nxt  = '0;
        armed_nxt = 1'b0;
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
        armed_nxt = 1'b0;
      end
    endcase
  end

  // Half-period counter, restarted on every edge and saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_c) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev         <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost_sticky  <= 1'b0;
    end else begin
      prev         <= lvl;
      rise_pulse   <= lvl & ~prev;
      fall_pulse   <= ~lvl & prev;
      period_valid <= edge_c & armed;
      if (edge_c && armed) begin
        half_period <= meas_c[CNT_W-1:0];
      end
      locked <= (state_nxt == LOCKED);
      // Setting the sticky flag takes priority over a coincident clear.
      if (state == LOCKED && state_nxt == LOST) begin
        lost_sticky <= 1'b1;
      end else if (clr_lost) begin
        lost_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk50k_monitor.sv
// Testbench for clk50k_monitor: table-driven lock scenarios plus hand-written sequences
// for timeout, sticky clear, reset while locked and glitch handling. A scoreboard queue
// holds the expected half-period for every measured edge driven on clk_in.
module tb_clk50k_monitor;

  localparam int unsigned CNT_W = 16;
`ifdef CLKMON_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             clk_in   = 1'b0;
  logic             clr_lost = 1'b0;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             locked;
  logic             lost_sticky;

  clk50k_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_in       (clk_in),
    .clr_lost     (clr_lost),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost_sticky  (lost_sticky)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int rise_n = 0;
  int fall_n = 0;
  int last_edge = 0;
  bit armed_m = 1'b0;
  int exp_q[$];
  int mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: count pulses, compare each measurement against the scoreboard.
  always @(negedge clk) begin
    if (rise_pulse) rise_n++;
    if (fall_pulse) fall_n++;
    if (period_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_period_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("half_period", int'(half_period), mon_e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle clk_in; armed edges expect a measurement of the cycles since the last edge.
  task automatic toggle();
    clk_in = ~clk_in;
    if (armed_m) exp_q.push_back(cyc - last_edge);
    armed_m   = 1'b1;
    last_edge = cyc;
  endtask

  task automatic drive(input int h, input int n);
    for (int i = 0; i < n; i++) begin
      toggle();
      tick(h);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},   int'(rise_pulse),   0);
    check({tag, "_fall"},   int'(fall_pulse),   0);
    check({tag, "_hp"},     int'(half_period),  0);
    check({tag, "_pv"},     int'(period_valid), 0);
    check({tag, "_locked"}, int'(locked),       0);
    check({tag, "_lost"},   int'(lost_sticky),  0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    clk_in = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n   = 1'b1;
    armed_m = 1'b0;
    exp_q.delete();
    tick(5);
    rise_n = 0;
    fall_n = 0;
  endtask

  typedef struct {
    int half;
    int edges;
    int exp_locked;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{half: 100, edges: 4,  exp_locked: 0};
    vecs[1] = '{half: 100, edges: 5,  exp_locked: 1};
    vecs[2] = '{half: 103, edges: 12, exp_locked: 0};
    vecs[3] = '{half: 102, edges: 5,  exp_locked: 1};
    vecs[4] = '{half: 102, edges: 4,  exp_locked: 0};
    vecs[5] = '{half: 98,  edges: 5,  exp_locked: 1};
    vecs[6] = '{half: 97,  edges: 8,  exp_locked: 0};

    tick(2);

    // Lock behaviour across half-periods inside and outside tolerance.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      drive(vecs[v].half, vecs[v].edges);
      check($sformatf("locked_h%0d_e%0d", vecs[v].half, vecs[v].edges),
            int'(locked), vecs[v].exp_locked);
      check($sformatf("pulses_h%0d", vecs[v].half), rise_n + fall_n, vecs[v].edges);
      check($sformatf("drained_h%0d", vecs[v].half), exp_q.size(), 0);
    end

    // Loss of clock exactly TIMEOUT cycles after the last edge, then clear.
    do_reset();
    drive(100, 5);
    check("to_locked", int'(locked), 1);
    tick(302 + LAT);
    check("to_still_locked", int'(locked), 1);
    check("to_not_lost_yet", int'(lost_sticky), 0);
    tick(1);
    armed_m = 1'b0;
    check("to_unlocked", int'(locked), 0);
    check("to_lost", int'(lost_sticky), 1);
    tick(20);
    check("to_lost_held", int'(lost_sticky), 1);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    check("to_cleared", int'(lost_sticky), 0);

    // clr_lost in the same cycle as the loss: set wins.
    do_reset();
    drive(100, 5);
    tick(302 + LAT);
    clr_lost = 1'b1;
    tick(1);
    clr_lost = 1'b0;
    armed_m  = 1'b0;
    check("same_cyc_unlocked", int'(locked), 0);
    check("same_cyc_lost", int'(lost_sticky), 1);

    // One-cycle reset while locked, then full relock.
    do_reset();
    drive(100, 6);
    check("rst_pre_locked", int'(locked), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_all_zero("midrst");
    armed_m = 1'b0;
    drive(100, 4);
    check("relock_4_edges", int'(locked), 0);
    drive(100, 1);
    check("relock_5_edges", int'(locked), 1);
    check("relock_drained", exp_q.size(), 0);

    // One-cycle glitch mid half-period while locked.
    do_reset();
    drive(100, 5);
    toggle();
    tick(50);
    check("gl_pre_locked", int'(locked), 1);
    rise_n = 0;
    fall_n = 0;
`ifdef CLKMON_GLITCH_FILTER_EN
    clk_in = ~clk_in;
    tick(1);
    clk_in = ~clk_in;
    tick(20);
    check("gl_locked", int'(locked), 1);
    check("gl_pulses", rise_n + fall_n, 0);
    check("gl_lost", int'(lost_sticky), 0);
    tick(29);
    toggle();
    tick(10 + LAT);
    check("gl_after_locked", int'(locked), 1);
    check("gl_after_drained", exp_q.size(), 0);
`else
    toggle();
    tick(1);
    toggle();
    armed_m = 1'b0;
    tick(20);
    check("gl_rise", rise_n, 1);
    check("gl_fall", fall_n, 1);
    check("gl_hp", int'(half_period), 1);
    check("gl_locked", int'(locked), 0);
    check("gl_lost", int'(lost_sticky), 1);
    check("gl_drained", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
